rtf65002_multdiv: RTL and testbench

RTF65002_MULTDIV -- requirements
Module: rtf65002_multdiv

---
 rtl/rtf65002_multdiv.sv | 140 ++++++++++++++
 tb/tb_rtf65002_multdiv.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtf65002_multdiv.sv
// Iterative 32x32 multiplier / restoring divider: one bit per cycle for 32 cycles,
// then one sign-fixup cycle. Divide by zero completes immediately.
module rtf65002_multdiv (
  input  logic        rst,
  input  logic        clk,
  input  logic        ld,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] res,
  output logic        busy,
  output logic        done,
  output logic        dvz
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_op;
  logic        r_sa, r_sb;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [63:0] r_prod;
  logic [31:0] r_res;
  logic        r_done, r_dvz;

  // op[0] marks the signed variants; op 2..5 are divide/modulo
  logic        w_accept, w_is_div_in, w_dvz_in;
  logic [31:0] w_abs_a, w_abs_b;
  assign w_accept    = ld && (op <= 3'd5) && (r_state == IDLE || r_state == DONE);
  assign w_is_div_in = op[2] | op[1];
  assign w_dvz_in    = w_is_div_in && (b == 32'd0);
  assign w_abs_a     = (op[0] && a[31]) ? -a : a;
  assign w_abs_b     = (op[0] && b[31]) ? -b : b;

  // Multiply: {hi, lo} with lo preloaded with the multiplier, shifted right each step
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide: {rem, quo}, the shifted remainder needs 33 bits for the compare
  logic [32:0] w_div_rem;
  logic [31:0] w_div_sub;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  assign w_div_rem  = r_acc[63:31];
  assign w_div_ge   = w_div_rem >= {1'b0, r_opnd};
  assign w_div_sub  = w_div_rem[31:0] - r_opnd;
  assign w_div_next = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

  logic        w_is_mul, w_neg_q, w_neg_r;
  logic [31:0] w_quo, w_rem;
  logic [63:0] w_mprod, w_fix_prod;
  logic [31:0] w_fix_res;
  assign w_is_mul   = (r_op[2:1] == 2'b00);
  assign w_neg_q    = r_op[0] & (r_sa ^ r_sb);
  assign w_neg_r    = r_op[0] & r_sa;
  assign w_quo      = w_neg_q ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem      = w_neg_r ? -r_acc[63:32] : r_acc[63:32];
  assign w_mprod    = w_neg_q ? -r_acc : r_acc;
  assign w_fix_prod = w_is_mul ? w_mprod : {w_rem, w_quo};
  assign w_fix_res  = w_is_mul ? w_mprod[31:0] : (r_op[2] ? w_rem : w_quo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_accept) w_state_next = w_dvz_in ? DONE : RUN;
      RUN:        if (r_cnt == 6'd31) w_state_next = FIX;
      FIX:        w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= 3'd0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_cnt  <= 6'd0;
      r_acc  <= 64'd0;
      r_opnd <= 32'd0;
      r_prod <= 64'd0;
      r_res  <= 32'd0;
      r_done <= 1'b0;
      r_dvz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_op  <= op;
            r_sa  <= a[31];
            r_sb  <= b[31];
            r_cnt <= 6'd0;
            if (w_is_div_in) begin
              r_acc  <= {32'd0, w_abs_a};
              r_opnd <= w_abs_b;
            end else begin
              r_acc  <= {32'd0, w_abs_b};
              r_opnd <= w_abs_a;
            end
            if (w_dvz_in) begin
              r_done <= 1'b1;
              r_dvz  <= 1'b1;
              r_prod <= {a, 32'hFFFF_FFFF};
              r_res  <= op[2] ? a : 32'hFFFF_FFFF;
            end else begin
              r_done <= 1'b0;
              r_dvz  <= 1'b0;
            end
          end
        end
        RUN: begin
          r_acc <= w_is_mul ? w_mul_next : w_div_next;
          r_cnt <= r_cnt + 6'd1;
        end
        FIX: begin
          r_prod <= w_fix_prod;
          r_res  <= w_fix_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN) || (r_state == FIX);
  assign done = r_done;
  assign dvz  = r_dvz;
  assign prod = r_prod;
  assign res  = r_res;

endmodule

// File: tb/tb_rtf65002_multdiv.sv
// Self-checking bench: directed vectors plus randomized ops against an arithmetic model.
module tb_rtf65002_multdiv;

  logic        rst, clk, ld;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [63:0] prod;
  logic [31:0] res;
  logic        busy, done, dvz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_edge = 0;

  rtf65002_multdiv dut (
    .rst(rst), .clk(clk), .ld(ld), .op(op), .a(a), .b(b),
    .prod(prod), .res(res), .busy(busy), .done(done), .dvz(dvz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero,
  // remainder follows the dividend, matching the required semantics.
  function automatic logic [63:0] m_prod(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [31:0] q, m;
    sx = o[0] ? longint'($signed(x)) : longint'({32'd0, x});
    sy = o[0] ? longint'($signed(y)) : longint'({32'd0, y});
    if (o < 3'd2) return 64'(sx * sy);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    q = 32'(sx / sy);
    m = 32'(sx % sy);
    return {m, q};
  endfunction

  function automatic logic [31:0] m_res(input logic [2:0] o, input logic [63:0] p);
    return (o >= 3'd4) ? p[63:32] : p[31:0];
  endfunction

  // Drive one ld pulse; on return we are 1 time unit after the accepting edge N.
  task automatic start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    n_edge = cyc;
  endtask

  // Latency = edges after N until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    lat = done ? (cyc - n_edge) : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #1;
    checks++;
    if ({busy, done, dvz} !== 3'b000 || prod !== 64'd0 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: busy/done/dvz=%b prod=%h res=%h want 000/0/0", {busy, done, dvz}, prod, res);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dvz} !== 3'b000 || prod !== 64'd0 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset_clocked: busy/done/dvz=%b prod=%h res=%h want 000/0/0", {busy, done, dvz}, prod, res);
    end
    @(negedge clk) rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_mulu();
    int lat;
    start(3'd0, 32'hFFFF_FFFF, 32'h2);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL mulu_busy: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mulu_latency: got %0d want 33", lat); end
    checks++;
    if (prod !== 64'h0000_0001_FFFF_FFFE || res !== 32'hFFFF_FFFE || busy !== 1'b0 || dvz !== 1'b0) begin
      errors++;
      $display("FAIL mulu_result: prod=%h res=%h busy=%b dvz=%b want 00000001fffffffe fffffffe 0 0", prod, res, busy, dvz);
    end
    $display("MULU ffffffff*2 -> prod=%h res=%h lat=%0d", prod, res, lat);
  endtask

  task automatic test_muls();
    int lat;
    start(3'd1, 32'hFFFF_FFFD, 32'h7);
    wait_done(lat);
    checks++;
    if (prod !== 64'hFFFF_FFFF_FFFF_FFEB || res !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL muls_neg: prod=%h res=%h want ffffffffffffffeb ffffffeb", prod, res);
    end
    $display("MULS -3*7 -> prod=%h", prod);
    start(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    checks++;
    if (prod !== 64'h4000_0000_0000_0000 || lat !== 33) begin
      errors++; $display("FAIL muls_minmin: prod=%h lat=%0d want 4000000000000000 33", prod, lat);
    end
    $display("MULS 80000000^2 -> prod=%h", prod);
  endtask

  task automatic test_divs_mods();
    int lat;
    start(3'd3, 32'hFFFF_FFF9, 32'h2);
    wait_done(lat);
    checks++;
    if (res !== 32'hFFFF_FFFD || prod !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL divs: res=%h prod=%h want fffffffd fffffffffffffffd", res, prod);
    end
    $display("DIVS -7/2 -> res=%h", res);
    start(3'd5, 32'hFFFF_FFF9, 32'h2);
    wait_done(lat);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mods: res=%h want ffffffff", res);
    end
    $display("MODS -7%%2 -> res=%h", res);
    start(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    checks++;
    if (res !== 32'h8000_0000 || prod[63:32] !== 32'd0 || dvz !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL divs_overflow: res=%h rem=%h dvz=%b lat=%0d want 80000000 0 0 33", res, prod[63:32], dvz, lat);
    end
    $display("DIVS 80000000/-1 -> res=%h", res);
  endtask

  task automatic test_dvz();
    start(3'd2, 32'h1234, 32'd0);
    checks++;
    if (done !== 1'b1 || dvz !== 1'b1 || res !== 32'hFFFF_FFFF || prod !== 64'h0000_1234_FFFF_FFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL dvz_immediate: done=%b dvz=%b res=%h prod=%h busy=%b want 1 1 ffffffff 00001234ffffffff 0",
               done, dvz, res, prod, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || dvz !== 1'b1 || res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dvz_hold: done=%b dvz=%b res=%h want 1 1 ffffffff", done, dvz, res);
    end
    $display("DIVU 1234/0 -> res=%h prod=%h dvz=%b", res, prod, dvz);
  endtask

  task automatic test_back_to_back();
    int lat;
    start(3'd0, 32'd3, 32'd5);
    checks++;
    if (done !== 1'b0 || dvz !== 1'b0) begin
      errors++; $display("FAIL b2b_clear: done=%b dvz=%b want 0 0", done, dvz);
    end
    wait_done(lat);
    checks++;
    if (prod !== 64'd15 || lat !== 33) begin
      errors++; $display("FAIL b2b_result: prod=%h lat=%0d want 15 33", prod, lat);
    end
    $display("MULU 3*5 from DONE -> prod=%h", prod);
  endtask

  task automatic test_reserved();
    @(negedge clk);
    op = 3'd6; a = 32'd9; b = 32'd9; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || prod !== 64'd15 || res !== 32'd15) begin
      errors++; $display("FAIL reserved_op: done=%b busy=%b prod=%h res=%h want 1 0 15 15", done, busy, prod, res);
    end
    $display("reserved op 6 ignored, prod=%h", prod);
  endtask

  task automatic test_operand_change();
    int lat;
    start(3'd3, 32'd100, 32'd7);
    a = $urandom; b = 32'd0;
    wait_done(lat);
    checks++;
    if (res !== 32'd14 || prod[63:32] !== 32'd2 || dvz !== 1'b0) begin
      errors++; $display("FAIL operand_latch: res=%h rem=%h dvz=%b want e 2 0", res, prod[63:32], dvz);
    end
    $display("DIVS 100/7 with operands changed -> res=%h", res);
  endtask

  task automatic test_busy_ignore();
    int lat;
    start(3'd0, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 3'd2; a = 32'd5; b = 32'd0; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_state: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat);
    checks++;
    if (prod !== 64'd3000 || dvz !== 1'b0 || lat !== 33) begin
      errors++; $display("FAIL busy_ignore_result: prod=%h dvz=%b lat=%0d want bb8 0 33", prod, dvz, lat);
    end
    $display("MULU 1000*3 with ld during RUN -> prod=%h", prod);
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    start(3'd1, $urandom, $urandom);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, dvz} !== 3'b000 || prod !== 64'd0 || res !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: busy/done/dvz=%b prod=%h res=%h want 000/0/0", {busy, done, dvz}, prod, res);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done || busy || prod != 64'd0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_result: activity seen=%b want 0", seen);
    end
    start(3'd0, 32'd7, 32'd6);
    wait_done(lat);
    checks++;
    if (prod !== 64'd42 || lat !== 33) begin
      errors++; $display("FAIL first_after_reset: prod=%h lat=%0d want 2a 33", prod, lat);
    end
    $display("reset abort, then MULU 7*6 -> prod=%h lat=%0d", prod, lat);
  endtask

  task automatic test_random();
    int lat, want_lat;
    logic [2:0]  o;
    logic [31:0] x, y, want_res;
    logic [63:0] want_prod;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 16));
        2: x = 32'h8000_0000;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      want_prod = m_prod(o, x, y);
      want_res  = m_res(o, want_prod);
      want_lat  = (o >= 3'd2 && y == 32'd0) ? 0 : 33;
      start(o, x, y);
      wait_done(lat);
      checks++;
      if (prod !== want_prod || res !== want_res || lat !== want_lat || dvz !== (want_lat == 0)) begin
        errors++;
        $display("FAIL random_%0d: op=%0d a=%h b=%h prod=%h res=%h lat=%0d dvz=%b want %h %h %0d",
                 i, o, x, y, prod, res, lat, dvz, want_prod, want_res, want_lat);
      end else begin
        $display("op=%0d a=%h b=%h -> prod=%h res=%h lat=%0d", o, x, y, prod, res, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_muls();
    test_divs_mods();
    test_dvz();
    test_back_to_back();
    test_reserved();
    test_operand_change();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
